// File: rtl/mult_div_pkg.sv
// ---------------------------------------------------------------------------
// mult_div_pkg
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM state encoding, iteration count and counter width, plus a
// small magnitude helper used by the signed divide path.
// ---------------------------------------------------------------------------
package mult_div_pkg;

    localparam int ITERATIONS = 32;
    localparam int CNT_W      = 6;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude 2^31.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mult_div_unit_div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration on unsigned magnitudes.
// {rem, quo} is shifted left one bit, the divisor is trial-subtracted from
// the widened remainder, and the new quotient bit is shifted in at the bottom.
// Ports:
//   i_rem     [31:0]  partial remainder in (always < divisor)
//   i_quo     [31:0]  dividend bits still to consume / quotient bits so far
//   i_divisor [31:0]  divisor magnitude (non-zero)
//   o_rem     [31:0]  partial remainder out
//   o_quo     [31:0]  shifted quotient with the new bit in [0]
// Only built when MULT_DIV_DIVIDE_EN is defined.
// ---------------------------------------------------------------------------
`ifdef MULT_DIV_DIVIDE_EN
module div_step (
    input  logic [31:0] i_rem,
    input  logic [31:0] i_quo,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_rem,
    output logic [31:0] o_quo
);

    logic [32:0] w_shift;
    logic [32:0] w_diff;

    // Remainder < divisor <= 2^31, so the shifted value fits in 33 bits and
    // bit 32 of the difference is a clean borrow flag.
    assign w_shift = {i_rem, i_quo[31]};
    assign w_diff  = w_shift - {1'b0, i_divisor};

    always_comb begin
        o_rem = w_shift[31:0];
        o_quo = {i_quo[30:0], 1'b0};
        if (!w_diff[32]) begin
            o_rem = w_diff[31:0];
            o_quo = {i_quo[30:0], 1'b1};
        end
    end

endmodule
`endif

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
// Iterative signed multiply (radix-2 Booth) and signed restoring divide with
// HI/LO result registers.  Handshake: start is sampled only in IDLE; busy is
// high from the accepting edge until the edge leaving DONE; done (and
// div_zero, when applicable) pulses for the single DONE cycle, and hi/lo are
// already updated during that cycle.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   start, op         request strobe and operation (OP_MULT / OP_DIV)
//   a, b     [31:0]   operands (multiplicand/multiplier or dividend/divisor)
//   busy, done        status
//   hi, lo   [31:0]   result registers
//   div_zero          divide-by-zero / divide-unavailable flag, with done
//   dbg_state         current FSM state
// Macro MULT_DIV_DIVIDE_EN: when defined the divide datapath is built; when
// undefined every DIV request completes immediately with div_zero.
// ---------------------------------------------------------------------------
module mult_div_unit
    import mult_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero,
    output state_t      dbg_state
);

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [32:0]        r_acc;      // Booth accumulator / divide remainder
    logic [31:0]        r_q;        // Booth multiplier / divide quotient
    logic               r_q1;       // Booth q[-1]
    logic               r_div_zero;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic               w_last;
    logic               w_dz_accept;
    logic [32:0]        w_m_ext;
    logic [32:0]        w_b_sum;
    logic [32:0]        w_b_acc;
    logic [31:0]        w_b_q;

    // Cycle after acceptance (cnt 0) loads the working registers; iterations
    // run at cnt 1..32 and the last one commits hi/lo directly.
    assign w_last = (r_cnt == CNT_W'(ITERATIONS));

`ifdef MULT_DIV_DIVIDE_EN
    assign w_dz_accept = (op == OP_DIV) && (b == 32'd0);
`else
    assign w_dz_accept = (op == OP_DIV);
`endif

    // Booth: 33-bit accumulator so that subtracting -2^31 cannot overflow.
    assign w_m_ext = {r_a[31], r_a};

    always_comb begin
        w_b_sum = r_acc;
        case ({r_q[0], r_q1})
            2'b01:   w_b_sum = r_acc + w_m_ext;
            2'b10:   w_b_sum = r_acc - w_m_ext;
            default: w_b_sum = r_acc;
        endcase
    end

    assign w_b_acc = {w_b_sum[32], w_b_sum[32:1]};
    assign w_b_q   = {w_b_sum[0], r_q[31:1]};

`ifdef MULT_DIV_DIVIDE_EN
    logic [31:0] w_divisor;
    logic [31:0] w_d_rem;
    logic [31:0] w_d_quo;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;

    assign w_divisor = abs32(r_b);

    div_step u_div_step (
        .i_rem     (r_acc[31:0]),
        .i_quo     (r_q),
        .i_divisor (w_divisor),
        .o_rem     (w_d_rem),
        .o_quo     (w_d_quo)
    );

    // Quotient negative when operand signs differ; remainder follows the
    // dividend.  Only consumed on the last iteration.
    assign w_q_fix = (r_a[31] ^ r_b[31]) ? (~w_d_quo + 32'd1) : w_d_quo;
    assign w_r_fix = r_a[31] ? (~w_d_rem + 32'd1) : w_d_rem;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next_state;
    end

    // FSM next state and status outputs
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        div_zero     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next_state = (op == OP_DIV) ? S_DIV : S_MULT;
            end
            S_MULT: begin
                busy = 1'b1;
                if (w_last) w_next_state = S_DONE;
            end
            S_DIV: begin
                busy = 1'b1;
                if (r_div_zero || w_last) w_next_state = S_DONE;
            end
            S_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                div_zero     = r_div_zero;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_q        <= '0;
            r_q1       <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_cnt      <= '0;
                        r_div_zero <= w_dz_accept;
                    end
                end
                S_MULT: begin
                    if (r_cnt == '0) begin
                        r_acc <= '0;
                        r_q   <= r_b;
                        r_q1  <= 1'b0;
                        r_cnt <= CNT_W'(1);
                    end else begin
                        r_acc <= w_b_acc;
                        r_q   <= w_b_q;
                        r_q1  <= r_q[0];
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_hi <= w_b_acc[31:0];
                            r_lo <= w_b_q;
                        end
                    end
                end
                S_DIV: begin
`ifdef MULT_DIV_DIVIDE_EN
                    if (!r_div_zero) begin
                        if (r_cnt == '0) begin
                            r_acc <= '0;
                            r_q   <= abs32(r_a);
                            r_cnt <= CNT_W'(1);
                        end else begin
                            r_acc <= {1'b0, w_d_rem};
                            r_q   <= w_d_quo;
                            r_cnt <= r_cnt + CNT_W'(1);
                            if (w_last) begin
                                r_hi <= w_r_fix;
                                r_lo <= w_q_fix;
                            end
                        end
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign hi        = r_hi;
    assign lo        = r_lo;
    assign dbg_state = r_state;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL expose the following ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous assert, active-low.
- start  in  1  request strobe from the CPU control unit; sampled only in IDLE.
- op  in  1  operation select: 0 = MULT, 1 = DIV.
- a  in  32  operand A: multiplicand, or dividend (RegA).
- b  in  32  operand B: multiplier, or divisor (RegB).
- busy  out  1  high from acceptance until done.
- done  out  1  one-cycle pulse; result or exception is valid.
- hi  out  32  HI register.
- lo  out  32  LO register.
- div_zero  out  1  one-cycle pulse with done; DIV with b = 0.
REQ-002 The block SHALL use exactly one clock (clk) and one asynchronous, active-low reset (rst).

Function
REQ-003 The block SHALL implement four states: IDLE, MULT, DIV, DONE.
REQ-004 In IDLE, start=1 at rising edge N SHALL latch a, b and op, set busy, and move to MULT or DIV.
REQ-005 start asserted while busy=1 SHALL be ignored, with no effect on operands or state.
REQ-006 MULT SHALL use signed radix-2 Booth over 32 iterations, one per cycle, tracked by a 6-bit iteration counter.
REQ-007 The MULT result SHALL be the 64-bit two's-complement product, with hi = bits [63:32] and lo = bits [31:0].
REQ-008 DIV SHALL use signed restoring division over 32 iterations on operand magnitudes, with sign fix-up applied on the last iteration.
REQ-009 The DIV result SHALL be lo = quotient truncated toward zero and hi = remainder carrying the dividend's sign.
REQ-010 DIV 0x80000000 / 0xFFFFFFFF SHALL produce lo = 0x80000000, hi = 0 and no exception.
REQ-011 DIV with b = 0 SHALL go IDLE -> DONE at edge N+1 with div_zero=1 and hi/lo unchanged.
REQ-012 Otherwise, hi/lo SHALL update at edge N+33, which is also the edge entering DONE, so done=1 for the cycle after edge N+33.
REQ-013 DONE SHALL last exactly one cycle, then return to IDLE; busy SHALL fall on that same edge.
REQ-014 hi/lo SHALL hold their values between operations; intermediate iteration values SHALL never be visible on hi/lo.
REQ-015 Back-to-back operation: start held through DONE SHALL be accepted on the first IDLE cycle after DONE.
REQ-016 done and div_zero SHALL never be high outside DONE.

Reset
REQ-017 rst=0 at any time, including mid-iteration, SHALL immediately force IDLE and clear: busy, done, div_zero, hi, lo, the counter and the operand registers.
REQ-018 Any operation in progress at reset SHALL be discarded, with no partial result retained.
REQ-019 After rst deasserts, the first start SHALL be accepted at the next rising edge.

Configuration
REQ-020 Macro MULT_DIV_DIVIDE_EN SHALL control the divide datapath.
REQ-021 With MULT_DIV_DIVIDE_EN defined, op=1 SHALL behave per REQ-008 to REQ-011.
REQ-022 Without MULT_DIV_DIVIDE_EN, op=1 SHALL go IDLE -> DONE at edge N+1 with div_zero=1 and hi/lo unchanged, and no divide hardware or div_step instance SHALL exist.

Structure
REQ-023 Shared package mult_div_pkg SHALL hold the following, and the module SHALL use no local copies of them:
- op encodings OP_MULT/OP_DIV
- state encoding
- ITERATIONS = 32
- counter width = 6
REQ-024 One sub-module, div_step, SHALL be combinational and hold one restoring-division iteration: {rem, quo} in -> {rem, quo} out.
REQ-025 Booth multiply SHALL stay inline in mult_div_unit.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- MULT a=7, b=-3 -> at edge N+33: hi=0xFFFFFFFF, lo=0xFFFFFFEB; done one cycle; busy high from N to N+34.
- MULT a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- DIV a=5, b=0 with prior hi=0x11, lo=0x22 -> done and div_zero at edge N+1; hi=0x11, lo=0x22 unchanged.
- start re-pulsed with new operands at N+10 of a MULT -> ignored, original result delivered at N+33; then rst=0 at N+5 of a new op -> outputs 0 immediately, no done pulse.
- Build without MULT_DIV_DIVIDE_EN: DIV a=9, b=3 -> div_zero at N+1, hi/lo unchanged; MULT still correct.
